// File: rtl/fast_slow_handshake_tx.sv
// -----------------------------------------------------------------------------
// fast_slow_handshake_tx
//
// Source-side half of a toggle req/ack handshake. The block moves WIDTH-bit
// samples from the local (fast) clock domain to a slower consumer domain.
// A word is accepted via in_valid/in_ready and held stable on xfer_data. Each
// new word toggles xfer_req. The block then waits until the consumer's
// xfer_ack toggle, resynchronised through a SYNC_STAGES flop chain, matches
// xfer_req again.
//
// Ports
//   clk          in   1          local (fast) clock, rising edge
//   rst_n        in   1          synchronous reset, active low
//   in_data      in   WIDTH      sample to send
//   in_valid     in   1          in_data valid
//   in_ready     out  1          can accept (transfer on in_valid & in_ready)
//   xfer_data    out  WIDTH      held data towards the consumer (registered)
//   xfer_req     out  1          request toggle level (registered)
//   xfer_ack     in   1          ack toggle from the consumer (asynchronous)
//   busy         out  1          high while waiting for the ack
//   timeout_err  out  1          sticky: ack not seen within ACK_TIMEOUT cycles
//   proto_err    out  1          sticky: ack toggled while idle
//   xfer_count   out  CNT_WIDTH  completed transfers, wraps silently
//
// Parameters
//   WIDTH        sample width in bits
//   SYNC_STAGES  flops in the xfer_ack synchronizer (must be >= 2)
//   ACK_TIMEOUT  wait cycles before timeout_err is set; 0 disables the check
//   CNT_WIDTH    width of xfer_count
// -----------------------------------------------------------------------------
module fast_slow_handshake_tx #(
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACK_TIMEOUT = 0,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     xfer_data,
  output logic                 xfer_req,
  input  logic                 xfer_ack,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 proto_err,
  output logic [CNT_WIDTH-1:0] xfer_count
);

  // ---------------------------------------------------------------------------
  // Local constants
  // ---------------------------------------------------------------------------
  // The wait timer only has to count up to ACK_TIMEOUT and then sticks there.
  // With the timeout disabled a single constant-zero bit is kept so the
  // logic below needs no special case.
  localparam bit              TMO_EN  = (ACK_TIMEOUT > 0);
  localparam int unsigned     TMR_W   = TMO_EN ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(ACK_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                 state_q,    state_d;
  logic                   in_ready_q, in_ready_d;
  logic [WIDTH-1:0]       data_q,     data_d;
  logic                   req_q,      req_d;
  logic [TMR_W-1:0]       timer_q,    timer_d;
  logic                   tmo_q,      tmo_d;
  logic                   proto_q,    proto_d;
  logic [CNT_WIDTH-1:0]   count_q,    count_d;
  logic [SYNC_STAGES-1:0] sync_q,     sync_d;

  logic ack_s;

  // ---------------------------------------------------------------------------
  // xfer_ack synchronizer
  // ---------------------------------------------------------------------------
  // Plain shift chain: stage 0 may go metastable, later stages give it a full
  // cycle each to resolve. ack_s is therefore SYNC_STAGES cycles behind the
  // pin. The chain needs at least two stages.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], xfer_ack};
  assign ack_s  = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a hold value first so that no path through
    // the case leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    in_ready_d = in_ready_q;
    data_d     = data_q;
    req_d      = req_q;
    timer_d    = timer_q;
    tmo_d      = tmo_q;
    proto_d    = proto_q;
    count_d    = count_q;

    case (state_q)
      ST_IDLE: begin
        // in_ready is registered. It comes up on the first edge after reset
        // and stays up while idle.
        in_ready_d = 1'b1;

        // While idle the ack level must equal the req level. A mismatch
        // means the consumer toggled without being asked. The error is only
        // flagged; a word is still accepted as normal.
        if (ack_s != req_q) begin
          proto_d = 1'b1;
        end

        if (in_valid && in_ready_q) begin
          data_d     = in_data;
          req_d      = ~req_q;
          in_ready_d = 1'b0;
          timer_d    = '0;
          state_d    = ST_WAIT_ACK;
        end
      end

      ST_WAIT_ACK: begin
        // Data and req stay frozen here. in_valid is not looked at, so an
        // ack and a new word arriving on the same edge cannot collide. The
        // word is taken on the following edge once in_ready is back.
        in_ready_d = 1'b0;

        if (ack_s == req_q) begin
          state_d    = ST_IDLE;
          in_ready_d = 1'b1;
          count_d    = count_q + CNT_ONE;
        end else begin
          if (timer_q != TMR_MAX) begin
            timer_d = timer_q + TMR_ONE;
          end
          // The timeout is only flagged; the request is never re-toggled
          // because that would desynchronise the receiver. A late ack
          // still completes the transfer.
          if (TMO_EN && (timer_d == TMR_MAX)) begin
            tmo_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous and covers every flop, including the
  // synchronizer chain. A reset in mid-transfer therefore returns xfer_req to
  // 0, and the consumer must be reset in the same window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      data_q     <= '0;
      req_q      <= 1'b0;
      timer_q    <= '0;
      tmo_q      <= 1'b0;
      proto_q    <= 1'b0;
      count_q    <= '0;
      sync_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the values from
      // before the edge, so the order of these lines does not matter.
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      data_q     <= data_d;
      req_q      <= req_d;
      timer_q    <= timer_d;
      tmo_q      <= tmo_d;
      proto_q    <= proto_d;
      count_q    <= count_d;
      sync_q     <= sync_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready    = in_ready_q;
  assign xfer_data   = data_q;
  assign xfer_req    = req_q;
  assign busy        = (state_q == ST_WAIT_ACK);
  assign timeout_err = tmo_q;
  assign proto_err   = proto_q;
  assign xfer_count  = count_q;

endmodule

// File: tb/tb_fast_slow_handshake_tx.sv
// -----------------------------------------------------------------------------
// tb_fast_slow_handshake_tx
//
// Directed bench for fast_slow_handshake_tx. Two instances share clk and rst_n:
//   u_dut : WIDTH=12, SYNC_STAGES=2, ACK_TIMEOUT=8, CNT_WIDTH=16
//   u_wrp : WIDTH=12, SYNC_STAGES=2, ACK_TIMEOUT=0, CNT_WIDTH=2 (counter wrap)
// Inputs are driven and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fast_slow_handshake_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // main instance
  logic [11:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] xfer_data;
  logic        xfer_req;
  logic        xfer_ack = 1'b0;
  logic        busy;
  logic        timeout_err;
  logic        proto_err;
  logic [15:0] xfer_count;

  // wrap instance
  logic [11:0] w_in_data = '0;
  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [11:0] w_xfer_data;
  logic        w_xfer_req;
  logic        w_xfer_ack = 1'b0;
  logic        w_busy;
  logic        w_timeout_err;
  logic        w_proto_err;
  logic [1:0]  w_xfer_count;

  int n_total = 0;
  int n_pass  = 0;

  fast_slow_handshake_tx #(
    .WIDTH(12), .SYNC_STAGES(2), .ACK_TIMEOUT(8), .CNT_WIDTH(16)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .xfer_data(xfer_data), .xfer_req(xfer_req), .xfer_ack(xfer_ack),
    .busy(busy), .timeout_err(timeout_err), .proto_err(proto_err),
    .xfer_count(xfer_count)
  );

  fast_slow_handshake_tx #(
    .WIDTH(12), .SYNC_STAGES(2), .ACK_TIMEOUT(0), .CNT_WIDTH(2)
  ) u_wrp (
    .clk(clk), .rst_n(rst_n),
    .in_data(w_in_data), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .xfer_data(w_xfer_data), .xfer_req(w_xfer_req), .xfer_ack(w_xfer_ack),
    .busy(w_busy), .timeout_err(w_timeout_err), .proto_err(w_proto_err),
    .xfer_count(w_xfer_count)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    xfer_ack   = 1'b0;
    w_in_valid = 1'b0;
    w_xfer_ack = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
  endtask

  // One complete transfer on the wrap instance: accept, echo ack, settle.
  task automatic wrap_xfer(input logic [11:0] d, inout logic exp_req);
    w_in_data  = d;
    w_in_valid = 1'b1;
    cyc(1);
    w_in_valid = 1'b0;
    exp_req    = ~exp_req;
    w_xfer_ack = exp_req;
    cyc(3);
  endtask

  initial begin
    logic exp_req;
    logic w_req;
    logic stable;

    // ---------------- 1: reset with in_valid held high ----------------
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 12'hFFF;
    cyc(3);
    check("rst_in_ready",  in_ready,  0);
    check("rst_xfer_req",  xfer_req,  0);
    check("rst_xfer_data", xfer_data, 12'h000);
    check("rst_busy",      busy,      0);
    check("rst_count",     xfer_count, 0);
    check("rst_errs",      {timeout_err, proto_err}, 0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rel_ready_before_edge", in_ready, 0);
    cyc(1);
    check("rel_ready_after_edge", in_ready, 1);

    // ---------------- 2: single word + same-edge behaviour ----------------
    in_data  = 12'h0A5;
    in_valid = 1'b1;
    cyc(1);
    check("single_data",  xfer_data, 12'h0A5);
    check("single_req",   xfer_req,  1);
    check("single_busy",  busy,      1);
    check("single_ready", in_ready,  0);
    // keep offering another word while waiting; it must be ignored
    in_data  = 12'h123;
    xfer_ack = 1'b1;
    cyc(2);
    check("single_wait_ready", in_ready,  0);
    check("single_wait_data",  xfer_data, 12'h0A5);
    cyc(1);
    check("single_done_ready", in_ready,   1);
    check("single_done_count", xfer_count, 1);
    check("single_done_busy",  busy,       0);
    check("single_done_data",  xfer_data,  12'h0A5);
    check("same_edge_req",     xfer_req,   1);
    cyc(1);
    check("next_edge_data", xfer_data, 12'h123);
    check("next_edge_req",  xfer_req,  0);
    check("next_edge_busy", busy,      1);
    in_valid = 1'b0;

    // ---------------- 3: stream of 20 words ----------------
    do_reset();
    exp_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_data  = 12'(i);
      in_valid = 1'b1;
      cyc(1);
      in_valid = 1'b0;
      exp_req  = ~exp_req;
      check("stream_req",  xfer_req, exp_req);
      check("stream_busy", busy, 1);
      stable = 1'b1;
      repeat (5) begin
        cyc(1);
        if (xfer_data !== 12'(i)) stable = 1'b0;
      end
      check("stream_data", xfer_data, i);
      xfer_ack = exp_req;
      repeat (3) begin
        if (busy === 1'b1 && xfer_data !== 12'(i)) stable = 1'b0;
        cyc(1);
      end
      check("stream_stable", stable, 1);
      check("stream_count", xfer_count, i + 1);
    end
    check("stream_final_count", xfer_count, 20);
    check("stream_final_ready", in_ready, 1);

    // ---------------- 4: timeout ----------------
    do_reset();
    check("tmo_clear", timeout_err, 0);
    in_data  = 12'h7FF;
    in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    cyc(7);
    check("tmo_at7",      timeout_err, 0);
    check("tmo_busy7",    busy, 1);
    cyc(1);
    check("tmo_at8",      timeout_err, 1);
    check("tmo_busy8",    busy, 1);
    cyc(4);
    xfer_ack = 1'b1;
    cyc(2);
    check("tmo_late_busy", busy, 1);
    cyc(1);
    check("tmo_late_done",  busy, 0);
    check("tmo_late_ready", in_ready, 1);
    check("tmo_late_count", xfer_count, 1);
    check("tmo_sticky",     timeout_err, 1);
    cyc(3);
    check("tmo_sticky2",    timeout_err, 1);

    // ---------------- 5: protocol error ----------------
    do_reset();
    check("proto_tmo_cleared", timeout_err, 0);
    check("proto_clear",       proto_err, 0);
    xfer_ack = 1'b1;
    cyc(2);
    check("proto_at2", proto_err, 0);
    cyc(1);
    check("proto_at3", proto_err, 1);
    cyc(4);
    check("proto_sticky", proto_err, 1);
    do_reset();
    check("proto_reset", proto_err, 0);

    // ---------------- 6: counter wrap and mid-transfer reset ----------------
    check("wrap_rst_count", w_xfer_count, 0);
    w_req = 1'b0;
    for (int k = 1; k <= 4; k++) wrap_xfer(12'(k), w_req);
    check("wrap_after4", w_xfer_count, 0);
    wrap_xfer(12'h005, w_req);
    check("wrap_after5", w_xfer_count, 1);
    wrap_xfer(12'h006, w_req);
    check("wrap_after6", w_xfer_count, 2);
    w_in_data  = 12'h3C3;
    w_in_valid = 1'b1;
    cyc(1);
    w_in_valid = 1'b0;
    check("mid_pre_req",  w_xfer_req, 1);
    check("mid_pre_busy", w_busy, 1);
    cyc(20);
    check("mid_no_timeout", w_timeout_err, 0);
    check("mid_still_busy", w_busy, 1);
    rst_n      = 1'b0;
    w_xfer_ack = 1'b0;
    cyc(1);
    check("mid_rst_req",   w_xfer_req,   0);
    check("mid_rst_busy",  w_busy,       0);
    check("mid_rst_count", w_xfer_count, 0);
    check("mid_rst_data",  w_xfer_data,  12'h000);
    check("mid_rst_ready", w_in_ready,   0);
    rst_n = 1'b1;
    cyc(1);
    check("mid_rel_ready", w_in_ready,  1);
    check("wrap_no_proto", w_proto_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
